// File: rtl/fifo_skew_sched_pkg.sv
// Shared definitions for the row-FIFO read scheduler and its companions.
package fifo_skew_sched_pkg;

    // Array geometry shared with the row FIFO bank.
    localparam int unsigned DefArraySize = 8;
    localparam int unsigned DefFifoSize  = 8;
    localparam int unsigned DefLenW      = 4;
    localparam int unsigned DefTW        = 5;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_skew_sched_if.sv
// Handshake bundle between the batch controller (master) and the skew scheduler (slave).
interface fifo_skew_sched_if #(
    parameter int unsigned ARRAY_SIZE = fifo_skew_sched_pkg::DefArraySize,
    parameter int unsigned LEN_W      = fifo_skew_sched_pkg::DefLenW
);
    logic                  start;
    logic [LEN_W-1:0]      vec_len;
    logic                  stall_in;
    logic [ARRAY_SIZE-1:0] fifo_empty;
    logic [ARRAY_SIZE-1:0] fifo_rd_en;
    logic [ARRAY_SIZE-1:0] row_valid;
    logic                  busy;
    logic                  done;
    logic                  err_uflow;
    logic                  err_cfg;

    modport master (
        output start, vec_len, stall_in, fifo_empty,
        input  fifo_rd_en, row_valid, busy, done, err_uflow, err_cfg
    );

    modport slave (
        input  start, vec_len, stall_in, fifo_empty,
        output fifo_rd_en, row_valid, busy, done, err_uflow, err_cfg
    );
endinterface

// File: rtl/fifo_skew_sched_skew_mask_gen.sv
// Diagonal wavefront mask: row r is active for len steps starting at step r.
// Purely combinational so the weight-load path can reuse it with its own counter.
module fifo_skew_sched_skew_mask_gen #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned T_W        = 5
) (
    input  logic [T_W-1:0]        t_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic [ARRAY_SIZE-1:0] sched_o
);

    logic [T_W-1:0] len_ext;
    assign len_ext = T_W'(len_i);

    // Per-row window compare; r+len evaluated at T_W bits, cannot wrap for legal lengths.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        localparam logic [T_W-1:0] RowIdx = T_W'(r);
        assign sched_o[r] = (t_i >= RowIdx) && (t_i < (RowIdx + len_ext));
    end

endmodule

// File: rtl/fifo_skew_sched.sv
// Read-side scheduler for the per-row input FIFOs of the systolic array.
// Drains len entries from every row with a one-cycle-per-row diagonal skew;
// any stall (external or a scheduled read on an empty FIFO) freezes the whole wavefront.
module fifo_skew_sched
    import fifo_skew_sched_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = DefArraySize,
    parameter int unsigned FIFO_SIZE  = DefFifoSize,
    parameter int unsigned LEN_W      = DefLenW,
    parameter int unsigned T_W        = DefTW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_skew_sched_if.slave   sched_io
);

    state_e                state_q;
    logic [T_W-1:0]        t_q;
    logic [LEN_W-1:0]      len_q;
    logic [ARRAY_SIZE-1:0] row_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_uflow_q;
    logic                  err_cfg_q;

    logic [ARRAY_SIZE-1:0] sched;
    logic [ARRAY_SIZE-1:0] rd_en;
    logic                  run;
    logic                  uflow_hit;
    logic                  stall;
    logic                  start_ok;
    logic                  cfg_bad;
    logic                  len_zero;
    logic [T_W-1:0]        last_t;
    logic [T_W-1:0]        t_d;

    fifo_skew_sched_skew_mask_gen #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .LEN_W      (LEN_W),
        .T_W        (T_W)
    ) u_mask (
        .t_i     (t_q),
        .len_i   (len_q),
        .sched_o (sched)
    );

    // Read enables and stall are combinational so a stall suppresses reads in the same cycle.
    always_comb begin
        run       = (state_q == StRun);
        uflow_hit = run && |(sched & sched_io.fifo_empty);
        stall     = sched_io.stall_in || uflow_hit;
        rd_en     = (run && !stall) ? sched : '0;
        t_d       = t_q + T_W'(1);
        // Row ARRAY_SIZE-1 issues its final read at step len+ARRAY_SIZE-2.
        last_t    = T_W'(len_q) + T_W'(ARRAY_SIZE) - T_W'(2);
        // A start arriving while the done pulse is still out is dropped (busy still high).
        start_ok  = (state_q == StIdle) && !busy_q && sched_io.start;
        cfg_bad   = (sched_io.vec_len > LEN_W'(FIFO_SIZE));
        len_zero  = (sched_io.vec_len == '0);
    end

    // Batch FSM, step counter, latched length, error flags and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            t_q         <= '0;
            len_q       <= '0;
            row_valid_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_uflow_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            row_valid_q <= rd_en;
            // done trails the DONE state by one cycle so it lines up with the registered outputs.
            done_q      <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        len_q       <= sched_io.vec_len;
                        t_q         <= '0;
                        busy_q      <= 1'b1;
                        err_uflow_q <= 1'b0;
                        err_cfg_q   <= cfg_bad;
                        state_q     <= (len_zero || cfg_bad) ? StDone : StRun;
                    end else if (done_q) begin
                        busy_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (uflow_hit) begin
                        err_uflow_q <= 1'b1;
                    end
                    if (!stall) begin
                        t_q <= t_d;
                        if (t_q == last_t) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: state_q <= StDone;
                StDone:  state_q <= StIdle;
            endcase
        end
    end

    assign sched_io.fifo_rd_en = rd_en;
    assign sched_io.row_valid  = row_valid_q;
    assign sched_io.busy       = busy_q;
    assign sched_io.done       = done_q;
    assign sched_io.err_uflow  = err_uflow_q;
    assign sched_io.err_cfg    = err_cfg_q;

endmodule
